// File: rtl/bpu_tagged_multiport.sv
// ---------------------------------------------------------------------------
// bpu_tagged_multiport
//   Dual-slot branch predictor sitting between fetch (lookup) and the memory
//   stage (resolve/update). It has a 2-bit bimodal BHT and a tagged BTB, both
//   2^IDX_W entries. An init sweep clears the tables after reset, one entry
//   per cycle, so the arrays need no reset and can be inferred as RAM.
//
//   Optional feature (macro BPU_GSHARE_EN): gshare indexing of the BHT. It
//   uses a speculative global history register and restores that register
//   when a branch is mispredicted.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   lookup_valid0/1            fetch lookup request (slot 0 older)
//   lookup_pc0/1               fetch PC
//   pred_taken0/1              predicted direction
//   pred_target0/1             predicted next PC
//   btb_hit0/1                 valid BTB entry with matching tag
//   ghr_snap0/1                GHR used for the lookup (0 without gshare)
//   upd_valid0/1               resolved branch (slot 0 older)
//   upd_pc0/1, upd_taken0/1    resolved PC and direction
//   upd_target0/1              resolved target
//   upd_mispred0/1             branch was mispredicted
//   upd_ghr0/1                 ghr_snap carried with the branch
//   ready                      tables initialised
// ---------------------------------------------------------------------------
module bpu_tagged_multiport #(
  parameter int PC_W  = 11,
  parameter int IDX_W = 6,
  parameter int TAG_W = 4,
  parameter int GHR_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lookup_valid0,
  input  logic [PC_W-1:0]  lookup_pc0,
  output logic             pred_taken0,
  output logic [PC_W-1:0]  pred_target0,
  output logic             btb_hit0,
  output logic [GHR_W-1:0] ghr_snap0,
  input  logic             lookup_valid1,
  input  logic [PC_W-1:0]  lookup_pc1,
  output logic             pred_taken1,
  output logic [PC_W-1:0]  pred_target1,
  output logic             btb_hit1,
  output logic [GHR_W-1:0] ghr_snap1,
  input  logic             upd_valid0,
  input  logic [PC_W-1:0]  upd_pc0,
  input  logic             upd_taken0,
  input  logic [PC_W-1:0]  upd_target0,
  input  logic             upd_mispred0,
  input  logic [GHR_W-1:0] upd_ghr0,
  input  logic             upd_valid1,
  input  logic [PC_W-1:0]  upd_pc1,
  input  logic             upd_taken1,
  input  logic [PC_W-1:0]  upd_target1,
  input  logic             upd_mispred1,
  input  logic [GHR_W-1:0] upd_ghr1,
  output logic             ready
);

  // state   | meaning
  // ST_INIT | sweeping tables, one entry per cycle; lookups/updates inert
  // ST_RUN  | normal prediction and update
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam int N = 1 << IDX_W;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   sweep_q, sweep_d;
  logic               run;

  logic [1:0]         bht       [N];
  logic               btb_valid [N];
  logic [TAG_W-1:0]   btb_tag   [N];
  logic [PC_W-1:0]    btb_tgt   [N];

  function automatic logic [IDX_W-1:0] idx_of(input logic [PC_W-1:0] pc);
    return pc[IDX_W-1:0];
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [PC_W-1:0] pc);
    return pc[IDX_W+TAG_W-1:IDX_W];
  endfunction

  function automatic logic [1:0] sat(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    else       return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      ST_INIT: begin
        sweep_d = sweep_q + IDX_W'(1);
        if (sweep_q == IDX_W'(N - 1)) state_d = ST_RUN;
      end
      default: ;
    endcase
  end

  assign run   = (state_q == ST_RUN);
  assign ready = run;

  // ---------------- history and BHT indexing ----------------
  logic [IDX_W-1:0] lk_bidx0, lk_bidx1, up_bidx0, up_bidx1;

`ifdef BPU_GSHARE_EN
  logic [GHR_W-1:0] ghr_q, ghr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    ghr_q <= '0;
    else if (run) ghr_q <= ghr_d;
  end

  // Speculative shifts in slot order; a mispredict restores from the
  // branch's own snapshot and discards this cycle's speculation.
  always_comb begin
    ghr_d = ghr_q;
    if (lookup_valid0 && btb_hit0) ghr_d = {ghr_d[GHR_W-2:0], pred_taken0};
    if (lookup_valid1 && btb_hit1) ghr_d = {ghr_d[GHR_W-2:0], pred_taken1};
    if (upd_valid0 && upd_mispred0)      ghr_d = {upd_ghr0[GHR_W-2:0], upd_taken0};
    else if (upd_valid1 && upd_mispred1) ghr_d = {upd_ghr1[GHR_W-2:0], upd_taken1};
  end

  assign lk_bidx0  = idx_of(lookup_pc0) ^ IDX_W'(ghr_q);
  assign lk_bidx1  = idx_of(lookup_pc1) ^ IDX_W'(ghr_q);
  assign up_bidx0  = idx_of(upd_pc0) ^ IDX_W'(upd_ghr0);
  assign up_bidx1  = idx_of(upd_pc1) ^ IDX_W'(upd_ghr1);
  assign ghr_snap0 = run ? ghr_q : '0;
  assign ghr_snap1 = run ? ghr_q : '0;

  logic unused_bits;
  assign unused_bits = ^{upd_pc0, upd_pc1, upd_ghr0[GHR_W-1], upd_ghr1[GHR_W-1]};
`else
  assign lk_bidx0  = idx_of(lookup_pc0);
  assign lk_bidx1  = idx_of(lookup_pc1);
  assign up_bidx0  = idx_of(upd_pc0);
  assign up_bidx1  = idx_of(upd_pc1);
  assign ghr_snap0 = '0;
  assign ghr_snap1 = '0;

  logic unused_bits;
  assign unused_bits = ^{lookup_valid0, lookup_valid1, upd_mispred0, upd_mispred1,
                         upd_ghr0, upd_ghr1, upd_pc0, upd_pc1};
`endif

  // ---------------- lookup (combinational, no bypass) ----------------
  always_comb begin
    btb_hit0     = run && btb_valid[idx_of(lookup_pc0)] &&
                   (btb_tag[idx_of(lookup_pc0)] == tag_of(lookup_pc0));
    pred_taken0  = btb_hit0 && bht[lk_bidx0][1];
    pred_target0 = pred_taken0 ? btb_tgt[idx_of(lookup_pc0)] : lookup_pc0 + PC_W'(1);

    btb_hit1     = run && btb_valid[idx_of(lookup_pc1)] &&
                   (btb_tag[idx_of(lookup_pc1)] == tag_of(lookup_pc1));
    pred_taken1  = btb_hit1 && bht[lk_bidx1][1];
    pred_target1 = pred_taken1 ? btb_tgt[idx_of(lookup_pc1)] : lookup_pc1 + PC_W'(1);
  end

  // ---------------- table writes (no reset: RAM-inferable) ----------------
  // When both slots hit the same counter, slot 1 is applied on top of
  // slot 0's result. Slot 1's write comes later, so it wins on conflicts.
  always_ff @(posedge clk) begin
    if (!run) begin
      bht[sweep_q]       <= 2'b01;
      btb_valid[sweep_q] <= 1'b0;
    end else begin
      if (upd_valid0)
        bht[up_bidx0] <= sat(bht[up_bidx0], upd_taken0);
      if (upd_valid1)
        bht[up_bidx1] <= (upd_valid0 && (up_bidx0 == up_bidx1)) ?
                         sat(sat(bht[up_bidx0], upd_taken0), upd_taken1) :
                         sat(bht[up_bidx1], upd_taken1);
      if (upd_valid0 && upd_taken0) begin
        btb_valid[idx_of(upd_pc0)] <= 1'b1;
        btb_tag[idx_of(upd_pc0)]   <= tag_of(upd_pc0);
        btb_tgt[idx_of(upd_pc0)]   <= upd_target0;
      end
      if (upd_valid1 && upd_taken1) begin
        btb_valid[idx_of(upd_pc1)] <= 1'b1;
        btb_tag[idx_of(upd_pc1)]   <= tag_of(upd_pc1);
        btb_tgt[idx_of(upd_pc1)]   <= upd_target1;
      end
    end
  end

endmodule

// File: tb/tb_bpu_tagged_multiport.sv
module tb_bpu_tagged_multiport;
  localparam int PC_W = 11, IDX_W = 6, TAG_W = 4, GHR_W = 6;
  localparam int N = 64;
  localparam int PC_MASK = (1 << PC_W) - 1;

  logic clk = 1'b0, reset = 1'b1;
  logic lookup_valid0 = 0, lookup_valid1 = 0;
  logic [PC_W-1:0] lookup_pc0 = '0, lookup_pc1 = '0;
  logic pred_taken0, pred_taken1, btb_hit0, btb_hit1, ready;
  logic [PC_W-1:0] pred_target0, pred_target1;
  logic [GHR_W-1:0] ghr_snap0, ghr_snap1;
  logic upd_valid0 = 0, upd_valid1 = 0, upd_taken0 = 0, upd_taken1 = 0;
  logic upd_mispred0 = 0, upd_mispred1 = 0;
  logic [PC_W-1:0] upd_pc0 = '0, upd_pc1 = '0, upd_target0 = '0, upd_target1 = '0;
  logic [GHR_W-1:0] upd_ghr0 = '0, upd_ghr1 = '0;

  bpu_tagged_multiport #(.PC_W(PC_W), .IDX_W(IDX_W), .TAG_W(TAG_W), .GHR_W(GHR_W)) dut (
    .clk(clk), .reset(reset),
    .lookup_valid0(lookup_valid0), .lookup_pc0(lookup_pc0),
    .pred_taken0(pred_taken0), .pred_target0(pred_target0),
    .btb_hit0(btb_hit0), .ghr_snap0(ghr_snap0),
    .lookup_valid1(lookup_valid1), .lookup_pc1(lookup_pc1),
    .pred_taken1(pred_taken1), .pred_target1(pred_target1),
    .btb_hit1(btb_hit1), .ghr_snap1(ghr_snap1),
    .upd_valid0(upd_valid0), .upd_pc0(upd_pc0), .upd_taken0(upd_taken0),
    .upd_target0(upd_target0), .upd_mispred0(upd_mispred0), .upd_ghr0(upd_ghr0),
    .upd_valid1(upd_valid1), .upd_pc1(upd_pc1), .upd_taken1(upd_taken1),
    .upd_target1(upd_target1), .upd_mispred1(upd_mispred1), .upd_ghr1(upd_ghr1),
    .ready(ready)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---- reference model: plain arrays, updates applied in slot order ----
  int m_bht [N];
  bit m_val [N];
  int m_tag [N];
  int m_tgt [N];
  bit m_run = 0;
  int init_cnt = 0;

  function automatic void m_clear();
    for (int i = 0; i < N; i++) begin m_bht[i] = 1; m_val[i] = 0; end
  endfunction

  function automatic void m_lookup(input int pc, output int hit, output int tk, output int tg);
    int idx, tag;
    idx = pc % N;
    tag = (pc / N) % 16;
    hit = (m_run && m_val[idx] && m_tag[idx] == tag) ? 1 : 0;
    tk  = (hit && m_bht[idx] >= 2) ? 1 : 0;
    tg  = tk ? m_tgt[idx] : (pc + 1) % (PC_MASK + 1);
  endfunction

  function automatic void m_apply(input bit v, input int pc, input bit t, input int tgt);
    int idx;
    if (!v) return;
    idx = pc % N;
    m_bht[idx] = t ? ((m_bht[idx] < 3) ? m_bht[idx] + 1 : 3)
                   : ((m_bht[idx] > 0) ? m_bht[idx] - 1 : 0);
    if (t) begin
      m_val[idx] = 1;
      m_tag[idx] = (pc / N) % 16;
      m_tgt[idx] = tgt;
    end
  endfunction

  // Let combinational outputs settle, then compare both slots with the model.
  task automatic settle();
    int h, t, g;
    #1;
    check("ready", ready, m_run);
    m_lookup(lookup_pc0, h, t, g);
    check("hit0", btb_hit0, h);
    check("taken0", pred_taken0, t);
    check("target0", pred_target0, g);
    check("ghr0", ghr_snap0, 0);
    m_lookup(lookup_pc1, h, t, g);
    check("hit1", btb_hit1, h);
    check("taken1", pred_taken1, t);
    check("target1", pred_target1, g);
    check("ghr1", ghr_snap1, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_run) begin
      m_apply(upd_valid0, upd_pc0, upd_taken0, upd_target0);
      m_apply(upd_valid1, upd_pc1, upd_taken1, upd_target1);
    end else if (!reset) begin
      init_cnt++;
      if (init_cnt == N) begin m_run = 1; m_clear(); end
    end
    #1;
  endtask

  task automatic clr_upd();
    upd_valid0 = 0; upd_valid1 = 0; upd_taken0 = 0; upd_taken1 = 0;
  endtask

  task automatic upd0(input int pc, input bit t, input int tgt);
    clr_upd();
    upd_valid0 = 1; upd_pc0 = pc[PC_W-1:0]; upd_taken0 = t; upd_target0 = tgt[PC_W-1:0];
  endtask

  function automatic int rnd_pc();
    return $urandom_range(0, 3) + ($urandom_range(0, 1) << IDX_W) +
           ($urandom_range(0, 1) << (IDX_W + TAG_W));
  endfunction

  initial begin
    int c;
    m_clear();
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // INIT lookup and init length
    lookup_valid0 = 1; lookup_pc0 = 11'h010;
    #1;
    check("init_taken", pred_taken0, 0);
    check("init_target", pred_target0, 11'h011);
    check("init_ready", ready, 0);
    upd0(11'h010, 1, 11'h7ff);  // must be ignored during INIT
    c = 0;
    while (!ready && c < 200) begin @(posedge clk); #1; c++; end
    check("init_len", c, N);
    m_run = 1; m_clear();
    clr_upd();
    settle();
    check("init_upd_ignored", btb_hit0, 0);

    // train 0x045 twice
    upd0(11'h045, 1, 11'h100); tick();
    tick();
    clr_upd();
    lookup_pc0 = 11'h045; lookup_pc1 = 11'h085;
    settle();
    check("t45_hit", btb_hit0, 1);
    check("t45_taken", pred_taken0, 1);
    check("t45_target", pred_target0, 11'h100);
    check("t85_hit", btb_hit1, 0);
    check("t85_target", pred_target1, 11'h086);

    // same-cycle dual update on 0x012
    upd0(11'h012, 1, 11'h020);
    upd_valid1 = 1; upd_pc1 = 11'h012; upd_taken1 = 0; upd_target1 = 11'h055;
    lookup_pc0 = 11'h012;
    settle();
    check("nobypass_hit", btb_hit0, 0);
    tick(); clr_upd();
    settle();
    check("dual_mix_hit", btb_hit0, 1);
    check("dual_mix_taken", pred_taken0, 0);
    upd0(11'h012, 1, 11'h020);
    upd_valid1 = 1; upd_pc1 = 11'h012; upd_taken1 = 1; upd_target1 = 11'h030;
    tick(); clr_upd();
    settle();
    check("dual_tk_taken", pred_taken0, 1);
    check("dual_tk_target", pred_target0, 11'h030);

    // saturation down from 11, then clamp at 00
    for (int k = 0; k < 4; k++) begin
      upd0(11'h012, 0, 0); tick(); clr_upd(); settle();
      check($sformatf("dec%0d_taken", k), pred_taken0, (k == 0) ? 1 : 0);
      check($sformatf("dec%0d_hit", k), btb_hit0, 1);
    end
    upd0(11'h012, 1, 11'h030); tick(); clr_upd(); settle();
    check("clamp0_taken", pred_taken0, 0);
    upd0(11'h012, 1, 11'h030); tick(); clr_upd(); settle();
    check("clamp1_taken", pred_taken0, 1);

    // random phase
    for (int i = 0; i < 400; i++) begin
      lookup_valid0 = 1'($urandom); lookup_pc0 = rnd_pc();
      lookup_valid1 = 1'($urandom); lookup_pc1 = rnd_pc();
      upd_valid0 = 1'($urandom); upd_pc0 = rnd_pc(); upd_taken0 = 1'($urandom);
      upd_target0 = 11'($urandom); upd_mispred0 = 1'($urandom); upd_ghr0 = 6'($urandom);
      upd_valid1 = 1'($urandom); upd_pc1 = rnd_pc(); upd_taken1 = 1'($urandom);
      upd_target1 = 11'($urandom); upd_mispred1 = 1'($urandom); upd_ghr1 = 6'($urandom);
      settle();
      tick();
    end
    clr_upd();

    // train 0x045 again, then reset mid-RUN
    upd0(11'h045, 1, 11'h100); tick(); clr_upd();
    lookup_pc0 = 11'h045;
    settle();
    check("pre_rst_hit", btb_hit0, 1);
    reset = 1;
    #1;
    check("rst_ready", ready, 0);
    m_run = 0; init_cnt = 0;
    @(posedge clk); #1;
    reset = 0;
    for (int k = 0; k < N; k++) begin settle(); tick(); end
    settle();
    check("reinit_ready", ready, 1);
    check("reinit_hit", btb_hit0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bpu_tagged_multiport.md
Name: bpu_tagged_multiport

Overview:
- Parametrised successor to the two-slot bimodal branch predictor, sitting between fetch (lookup side) and memory stage (resolve/update side) of the superscalar core.
- Adds N-bit PC/table sizing, a tagged BTB, and an init sweep FSM in place of a whole-array reset.
- Adds ordered same-cycle dual update and optional gshare indexing with a speculative global history register (GHR) and mispredict recovery.

Parameters:
- PC_W, 11, PC width in words.
- IDX_W, 6, log2 of BHT/BTB entries.
- TAG_W, 4, BTB tag width. Require PC_W >= IDX_W+TAG_W.
- GHR_W, 6, history length. Require GHR_W <= IDX_W. Used only with gshare.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- lookup_valid0/1  in  1  fetch slot 0/1 lookup request; slot 0 is the older slot.
- lookup_pc0/1  in  PC_W  fetch slot PC.
- pred_taken0/1  out  1  predicted direction.
- pred_target0/1  out  PC_W  predicted next PC.
- btb_hit0/1  out  1  BTB tag match with valid entry.
- ghr_snap0/1  out  GHR_W  GHR value used for the lookup; pipelined with the branch.
- upd_valid0/1  in  1  resolved branch from the memory stage; slot 0 is the older slot.
- upd_pc0/1  in  PC_W  resolved branch PC.
- upd_taken0/1  in  1  actual direction.
- upd_target0/1  in  PC_W  actual target.
- upd_mispred0/1  in  1  direction or target mispredicted.
- upd_ghr0/1  in  GHR_W  ghr_snap carried with the branch.
- ready  out  1  high when tables are initialised.

Behaviour:
- Indexing:
  - btb_idx = pc[IDX_W-1:0].
  - tag = pc[IDX_W+TAG_W-1:IDX_W].
  - bht_idx = btb_idx, XORed with the zero-extended GHR when gshare is enabled.
- Lookup is combinational, same cycle, with no bypass: a same-cycle update to the same entry is not visible until the next cycle.
- btb_hit = BTB_valid[btb_idx] && BTB_tag[btb_idx] == tag.
- pred_taken = btb_hit && BHT[bht_idx][1].
- pred_target = pred_taken ? BTB_target : pc+1 (mod 2^PC_W).
- FSM, INIT -> RUN:
  - reset (any time, including mid-operation) forces INIT, sweep counter=0, GHR=0, ready=0.
  - INIT writes one entry per cycle: BHT=2'b01, BTB_valid=0.
  - After entry 2^IDX_W-1 is written, the FSM moves to RUN next cycle; ready=1 from then on.
  - INIT lasts exactly 2^IDX_W cycles after reset deassertion.
- During INIT:
  - outputs are pred_taken=0, btb_hit=0, pred_target=pc+1, ghr_snap=0.
  - update inputs are ignored.
- Counter update: 2-bit saturating; taken increments, not-taken decrements, clamped at 3 and 0.
- Same bht index on both update slots: result = sat(sat(c,taken0),taken1), i.e. slot 0 applied first.
- BTB update:
  - when upd_valid && upd_taken, write tag, target, valid=1.
  - a not-taken update leaves the BTB unchanged.
  - both slots taken to the same btb_idx: slot 1 data wins.
- Arrays are not reset asynchronously (RAM-inferable); only the FSM, sweep counter and GHR are async-reset.
- Out-of-range or X values on invalid slots are don't-care.

Optional Feature:
- Macro: BPU_GSHARE_EN.
- Defined:
  - bht_idx uses the GHR XOR.
  - Speculative GHR shift each RUN cycle: first for slot 0 if lookup_valid0 && btb_hit0 (shift in pred_taken0), then slot 1 likewise. Up to 2 bits per cycle.
  - Recovery: if upd_valid0 && upd_mispred0, next GHR = {upd_ghr0[GHR_W-2:0], upd_taken0}. Otherwise the same rule applies for slot 1.
  - Recovery overrides that cycle's speculative shift.
  - Update-side bht_idx uses upd_ghr.
- Undefined:
  - GHR logic is absent; bht_idx = btb_idx.
  - ghr_snap0/1 are tied to 0; upd_ghr and upd_mispred are ignored.

Test Plan:
- Reset pulse, then count cycles -> ready rises exactly 64 cycles after deassertion. A lookup at pc 0x010 during INIT gives taken=0, target 0x011.
- Update slot0 pc 0x045 taken target 0x100, twice -> lookup 0x045 gives hit=1, taken=1, target 0x100. Lookup 0x085 (same idx, different tag) gives hit=0, target 0x086.
- Both slots update pc 0x012, slot0 taken, slot1 not-taken, from counter 01 -> counter 01. Both taken with targets 0x020/0x030 -> BTB target 0x030.
- Counter at 11 with three not-taken updates -> 10, 01, 00. A further not-taken stays 00; pred_taken=0 after the second update.
- Reset asserted mid-RUN after training -> ready=0 immediately. After re-init, pc 0x045 gives hit=0.
- BPU_GSHARE_EN: two predicted-taken hits in one cycle shift GHR by 2 (0->0b000011). Mispredict on slot0 with upd_ghr=0b000101, taken=0 -> GHR=0b001010 next cycle, ignoring that cycle's shifts.
